// File: rtl/uart_pkg.sv
// Shared UART receive types: FSM state encoding, word-length codes and the
// helper that turns a word-length code into a data bit count.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic [1:0] WLS_5 = 2'd0;
  localparam logic [1:0] WLS_6 = 2'd1;
  localparam logic [1:0] WLS_7 = 2'd2;
  localparam logic [1:0] WLS_8 = 2'd3;

  function automatic logic [3:0] wls_to_bits(input logic [1:0] wls);
    case (wls)
      WLS_5:   return 4'd5;
      WLS_6:   return 4'd6;
      WLS_7:   return 4'd7;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous receive line; resets to the
// idle (high) level so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserialiser: oversampled start detection, mid-bit sampling of
// 5-8 data bits, optional parity and the first stop bit, one-deep holding register.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rxd,
  input  logic [1:0] cfg_wls,
  input  logic       cfg_stb,
  input  logic       cfg_pen,
  input  logic       cfg_eps,
  input  logic       cfg_sp,
  output logic [7:0] rx_data,
  output logic       rx_pe,
  output logic       rx_fe,
  output logic       rx_bi,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  logic rxd_s;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  // The receiver leaves STOP right after the first stop bit, so the number of
  // stop bits never changes what is sampled.
  logic stb_unused;
  assign stb_unused = cfg_stb;

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    fwls_q, fwls_d;
  logic          fpen_q, fpen_d;
  logic          feps_q, feps_d;
  logic          fsp_q, fsp_d;
  logic          par_q, par_d;
  logic          perr_q, perr_d;
  logic [7:0]    data_q, data_d;
  logic          pe_q, pe_d;
  logic          fe_q, fe_d;
  logic          bi_q, bi_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;

  logic          done;
  logic          exp_par;
  logic          last_bit;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fwls_d   = fwls_q;
    fpen_d   = fpen_q;
    feps_d   = feps_q;
    fsp_d    = fsp_q;
    par_d    = par_q;
    perr_d   = perr_q;
    done     = 1'b0;
    exp_par  = fsp_q ? ~feps_q : ((^shift_q) ^ ~feps_q);
    last_bit = ({1'b0, bit_q} == (wls_to_bits(fwls_q) - 4'd1));

    if (baud_tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            if (rxd_s) begin
              state_d = IDLE;
            end else begin
              // Frame format is frozen here so mid-frame cfg writes wait for the next character.
              state_d = DATA;
              cnt_d   = '0;
              bit_d   = '0;
              shift_d = '0;
              par_d   = 1'b0;
              perr_d  = 1'b0;
              fwls_d  = cfg_wls;
              fpen_d  = cfg_pen;
              feps_d  = cfg_eps;
              fsp_d   = cfg_sp;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_d          = '0;
            shift_d[bit_q] = rxd_s;
            bit_d          = bit_q + 3'd1;
            if (last_bit) state_d = fpen_q ? PARITY : STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (cnt_q == FULL_M1) begin
            cnt_d   = '0;
            par_d   = rxd_s;
            perr_d  = (rxd_s != exp_par);
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_d   = '0;
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Holding register: a completing character may replace one that is being
  // accepted in the same cycle; otherwise it is dropped and flagged.
  always_comb begin
    data_d  = data_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    bi_d    = bi_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (done) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        pe_d    = perr_q;
        fe_d    = ~rxd_s;
        bi_d    = (shift_q == 8'd0) && (!fpen_q || !par_q) && !rxd_s;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      fwls_q  <= '0;
      fpen_q  <= 1'b0;
      feps_q  <= 1'b0;
      fsp_q   <= 1'b0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      data_q  <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      bi_q    <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      fwls_q  <= fwls_d;
      fpen_q  <= fpen_d;
      feps_q  <= feps_d;
      fsp_q   <= fsp_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      data_q  <= data_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      bi_q    <= bi_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_pe      = pe_q;
  assign rx_fe      = fe_q;
  assign rx_bi      = bi_q;
  assign rx_valid   = valid_q;
  assign rx_overrun = ovr_q;
  assign rx_busy    = (state_q != IDLE);

endmodule
